// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: shares one single-port command RAM between N_PORTS requesters.
// A read or write transaction is converted into the RAM's two-command sequence
// (address, then data/read) and runs atomically, so the RAM's address register
// is never interleaved between requesters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req/req_rd                per-port request and read(1)/write(0) select
//   req_addr/req_wdata        per-port address / write data, port i at [8i+7:8i]
//   ack                       one-hot grant pulse; fields sampled this cycle
//   done                      one-hot completion pulse
//   rd_data                   read result, valid with done on a read
//   busy                      transaction in flight
//   proto_err                 read completed without ram_tx_valid
//   ram_din/ram_rx_valid      RAM command {op, payload} and strobe
//   ram_dout/ram_tx_valid     RAM read data and its valid flag
module ram_cmd_arbiter #(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             req,
    input  logic [N_PORTS-1:0]             req_rd,
    input  logic [N_PORTS*ADDR_SIZE-1:0]   req_addr,
    input  logic [N_PORTS*ADDR_SIZE-1:0]   req_wdata,
    output logic [N_PORTS-1:0]             ack,
    output logic [N_PORTS-1:0]             done,
    output logic [ADDR_SIZE-1:0]           rd_data,
    output logic                           busy,
    output logic                           proto_err,
    output logic [ADDR_SIZE+1:0]           ram_din,
    output logic                           ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]           ram_dout,
    input  logic                           ram_tx_valid
);

    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner_q;
    logic                   rd_q;
    logic [ADDR_SIZE-1:0]   wdata_q;

    logic                   gnt_valid;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   sel_rd;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;

    // Arbitration: round-robin searches from rr_ptr+1, fixed picks lowest index.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sel_rd    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            int unsigned idx;
            if (FIXED_PRIO != 0)
                idx = k;
            else
                idx = (int'(rr_ptr) + k + 1) % N_PORTS;
            if (req[PTR_W'(idx)] && !gnt_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
                sel_rd    = req_rd[PTR_W'(idx)];
                sel_addr  = req_addr[ADDR_SIZE*idx +: ADDR_SIZE];
                sel_wdata = req_wdata[ADDR_SIZE*idx +: ADDR_SIZE];
            end
        end
    end

    // Grant is visible in the same IDLE cycle it is taken; suppressed in reset.
    always_comb begin
        ack = '0;
        if (state == IDLE && !rst && gnt_valid)
            ack[gnt_idx] = 1'b1;
    end

    // RAM output is already registered, so read data and its valid are used directly.
    assign rd_data   = ram_dout;
    assign proto_err = (state == RESP) && rd_q && !ram_tx_valid;

    // Transaction sequencer: IDLE -> ADDR -> DATA -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ram_rx_valid <= 1'b0;
            ram_din      <= '0;
            done         <= '0;
            busy         <= 1'b0;
            rr_ptr       <= PTR_W'(N_PORTS - 1);
            owner_q      <= '0;
            rd_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_q      <= gnt_idx;
                        rd_q         <= sel_rd;
                        wdata_q      <= sel_wdata;
                        busy         <= 1'b1;
                        ram_rx_valid <= 1'b1;
                        ram_din      <= {(sel_rd ? 2'b10 : 2'b00), sel_addr};
                        if (FIXED_PRIO == 0)
                            rr_ptr <= gnt_idx;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    ram_din <= rd_q ? {2'b11, ADDR_SIZE'(0)} : {2'b01, wdata_q};
                    state   <= DATA;
                end
                DATA: begin
                    ram_rx_valid  <= 1'b0;
                    done[owner_q] <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
